// File: rtl/param_register_stack_if.sv
// Operand-stack bus: control/data inputs from the datapath and the stack
// status/operand outputs toward the ALU.
interface param_register_stack_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output stackOP, w,
    input  a, b, count, full, empty, overflow, underflow
  );

  modport slave (
    input  stackOP, w,
    output a, b, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/param_register_stack.sv
// Parametrised operand stack with dup/over, occupancy status and sticky
// overflow/underflow flags. Pointer-based storage, state updates on CLK negedge.
module param_register_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                  CLK,
  input  logic                  reset,
  param_register_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POPR = 3'd2,
    OP_POP  = 3'd3,
    OP_POP2 = 3'd4,
    OP_SWAP = 3'd5,
    OP_DUP  = 3'd6,
    OP_OVER = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             unf;

  op_e              op;
  logic [AW-1:0]    idx_free;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_sec;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] sec;
  logic             has1;
  logic             has2;
  logic             has_room;
  logic             opnd_ok;
  logic             room_ok;

  // Indices are only used when the matching precondition holds, so the
  // truncation at cnt == DEPTH or cnt < 2 never addresses a live write.
  assign idx_free = AW'(cnt);
  assign idx_top  = AW'(cnt - CW'(1));
  assign idx_sec  = AW'(cnt - CW'(2));
  assign top      = mem[idx_top];
  assign sec      = mem[idx_sec];

  assign has1     = (cnt >= CW'(1));
  assign has2     = (cnt >= CW'(2));
  assign has_room = (cnt <  CW'(DEPTH));

  always_comb begin
    op      = op_e'(bus.stackOP);
    opnd_ok = 1'b1;
    room_ok = 1'b1;
    case (op)
      OP_PUSH: room_ok = has_room;
      OP_POPR: opnd_ok = has2;
      OP_POP:  opnd_ok = has1;
      OP_POP2: opnd_ok = has2;
      OP_SWAP: opnd_ok = has2;
      OP_DUP: begin
        opnd_ok = has1;
        room_ok = has_room;
      end
      OP_OVER: begin
        opnd_ok = has2;
        room_ok = has_room;
      end
      default: ;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!opnd_ok) begin
      unf <= 1'b1;
    end else if (!room_ok) begin
      ovf <= 1'b1;
    end else begin
      case (op)
        OP_PUSH: begin
          mem[idx_free] <= bus.w;
          cnt           <= cnt + CW'(1);
        end
        OP_POPR: begin
          mem[idx_sec] <= bus.w;
          cnt          <= cnt - CW'(1);
        end
        OP_POP:  cnt <= cnt - CW'(1);
        OP_POP2: cnt <= cnt - CW'(2);
        OP_SWAP: begin
          mem[idx_top] <= sec;
          mem[idx_sec] <= top;
        end
        OP_DUP: begin
          mem[idx_free] <= top;
          cnt           <= cnt + CW'(1);
        end
        OP_OVER: begin
          mem[idx_free] <= sec;
          cnt           <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.a         = has1 ? top : '0;
  assign bus.b         = has2 ? sec : '0;
  assign bus.count     = cnt;
  assign bus.full      = (cnt == CW'(DEPTH));
  assign bus.empty     = (cnt == '0);
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_param_register_stack.sv
// Scoreboard bench for param_register_stack: a queue-based reference stack
// predicts outputs when each op is driven; results are checked after the negedge.
module tb_param_register_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic CLK;
  logic reset;

  param_register_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_register_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model[$];
  logic             m_ovf;
  logic             m_unf;
  int               total;
  int               bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_apply(input logic rst, input logic [2:0] op, input logic [WIDTH-1:0] wv);
    int               n;
    logic             need2;
    logic             need1;
    logic             room;
    logic [WIDTH-1:0] t;
    n = model.size();
    if (rst) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    need1 = (op == 3'd3) || (op == 3'd6);
    need2 = (op == 3'd2) || (op == 3'd4) || (op == 3'd5) || (op == 3'd7);
    room  = (op == 3'd1) || (op == 3'd6) || (op == 3'd7);
    if ((need1 && n < 1) || (need2 && n < 2)) begin
      m_unf = 1'b1;
    end else if (room && n >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      case (op)
        3'd1: model.push_back(wv);
        3'd2: begin
          void'(model.pop_back());
          void'(model.pop_back());
          model.push_back(wv);
        end
        3'd3: void'(model.pop_back());
        3'd4: begin
          void'(model.pop_back());
          void'(model.pop_back());
        end
        3'd5: begin
          t           = model[n-1];
          model[n-1]  = model[n-2];
          model[n-2]  = t;
        end
        3'd6: begin
          t = model[n-1];
          model.push_back(t);
        end
        3'd7: begin
          t = model[n-2];
          model.push_back(t);
        end
        default: ;
      endcase
    end
  endtask

  task automatic do_op(input string tag, input logic rst, input logic [2:0] op,
                       input logic [WIDTH-1:0] wv);
    exp_t e;
    exp_t g;
    int   n;
    @(posedge CLK);
    reset       = rst;
    bus.stackOP = op;
    bus.w       = wv;
    model_apply(rst, op, wv);
    n       = model.size();
    e.tag   = tag;
    e.a     = (n > 0) ? model[n-1] : '0;
    e.b     = (n > 1) ? model[n-2] : '0;
    e.count = CW'(n);
    e.full  = (n == DEPTH);
    e.empty = (n == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb.push_back(e);
    @(negedge CLK);
    #1;
    g = sb.pop_front();
    check({g.tag, ".a"},     32'(bus.a),         32'(g.a));
    check({g.tag, ".b"},     32'(bus.b),         32'(g.b));
    check({g.tag, ".count"}, 32'(bus.count),     32'(g.count));
    check({g.tag, ".full"},  32'(bus.full),      32'(g.full));
    check({g.tag, ".empty"}, 32'(bus.empty),     32'(g.empty));
    check({g.tag, ".ovf"},   32'(bus.overflow),  32'(g.ovf));
    check({g.tag, ".unf"},   32'(bus.underflow), 32'(g.unf));
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    reset       = 1'b0;
    bus.stackOP = 3'd0;
    bus.w       = '0;

    do_op("reset", 1'b1, 3'd0, '0);
    check("rst_empty", 32'(bus.empty), 32'd1);

    do_op("push1", 1'b0, 3'd1, 16'h1111);
    do_op("push2", 1'b0, 3'd1, 16'h2222);
    do_op("push3", 1'b0, 3'd1, 16'h3333);
    check("p3_a", 32'(bus.a), 32'h3333);
    check("p3_b", 32'(bus.b), 32'h2222);
    check("p3_count", 32'(bus.count), 32'd3);

    do_op("swap", 1'b0, 3'd5, '0);
    check("swap_a", 32'(bus.a), 32'h2222);
    check("swap_b", 32'(bus.b), 32'h3333);
    do_op("popr", 1'b0, 3'd2, 16'hABCD);
    check("popr_a", 32'(bus.a), 32'hABCD);
    check("popr_b", 32'(bus.b), 32'h1111);
    check("popr_count", 32'(bus.count), 32'd2);

    do_op("rst2", 1'b1, 3'd0, '0);
    do_op("push7", 1'b0, 3'd1, 16'h0007);
    do_op("push5", 1'b0, 3'd1, 16'h0005);
    do_op("dup", 1'b0, 3'd6, '0);
    check("dup_a", 32'(bus.a), 32'h5);
    check("dup_b", 32'(bus.b), 32'h5);
    do_op("over", 1'b0, 3'd7, '0);
    check("over_count", 32'(bus.count), 32'd4);
    do_op("pop2_third", 1'b0, 3'd4, '0);
    check("third_a", 32'(bus.a), 32'h5);
    check("third_b", 32'(bus.b), 32'h7);

    do_op("rst3", 1'b1, 3'd0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      do_op("fill", 1'b0, 3'd1, WIDTH'(i + 1));
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_a", 32'(bus.a), 32'(DEPTH));
    do_op("push_ovf", 1'b0, 3'd1, 16'hFFFF);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_a", 32'(bus.a), 32'(DEPTH));
    do_op("dup_ovf", 1'b0, 3'd6, '0);
    do_op("over_ovf", 1'b0, 3'd7, '0);
    do_op("pop_after_ovf", 1'b0, 3'd3, '0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("pop_ovf_a", 32'(bus.a), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) begin
      do_op("drain", 1'b0, 3'd3, '0);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);

    do_op("rst4", 1'b1, 3'd0, '0);
    do_op("u_pop", 1'b0, 3'd3, '0);
    do_op("u_pop2", 1'b0, 3'd4, '0);
    do_op("u_swap", 1'b0, 3'd5, '0);
    do_op("u_popr", 1'b0, 3'd2, 16'h5555);
    check("unf_flag", 32'(bus.underflow), 32'd1);
    check("unf_no_ovf", 32'(bus.overflow), 32'd0);
    do_op("one", 1'b0, 3'd1, 16'h0042);
    do_op("u_over1", 1'b0, 3'd7, '0);
    do_op("pop_last", 1'b0, 3'd3, '0);
    check("pop_last_a", 32'(bus.a), 32'd0);
    do_op("rst_unf", 1'b1, 3'd0, '0);
    check("rst_unf_clear", 32'(bus.underflow), 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_op("pre5", 1'b0, 3'd1, WIDTH'(16'h0100 + i));
    end
    do_op("rst_push", 1'b1, 3'd1, 16'h1234);
    check("rp_count", 32'(bus.count), 32'd0);
    do_op("push_after", 1'b0, 3'd1, 16'h1234);
    check("pa_a", 32'(bus.a), 32'h1234);

    // Random ops biased toward push so the stack reaches both ends.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      if (i > 300 && op == 3'd1) op = 3'd3;
      do_op("rand", 1'b0, op, WIDTH'($urandom));
    end

    if (sb.size() != 0) check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_register_stack.md
Name: param_register_stack

Overview:
- Parametrised successor to the processor's fixed 16-bit, 64-entry operand stack. Configurable data width and depth.
- Adds two ops: duplicate and over. Adds an occupancy count, full/empty status, and sticky overflow/underflow error flags.
- Sits between the datapath and the ALU operand inputs. The control unit drives `stackOP`; the ALU/writeback result drives `w`.

Parameters:
- WIDTH, 16, bits per stack entry.
- DEPTH, 64, number of entries. Must be ≥ 2.
- CW, $clog2(DEPTH+1), width of the occupancy count. Derived; not to be overridden.

Ports:
- CLK  input  1  system clock. All state updates on the negative edge.
- reset  input  1  synchronous, active-high. Sampled on the CLK negative edge.
- stackOP  input  3  operation code (see Behaviour).
- w  input  WIDTH  write data for push / pop-replace.
- a  output  WIDTH  top of stack. 0 when count == 0.
- b  output  WIDTH  second entry. 0 when count < 2.
- count  output  CW  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky. Set by a rejected op that needs room. Cleared only by reset.
- underflow  output  1  sticky. Set by a rejected op that needs operands. Cleared only by reset.

Behaviour:
- Timing and reset
  - All registers update on the CLK negedge.
  - a, b, count, full and empty are combinational from state. A result is visible right after the edge that performs the op; latency is 0 cycles past the edge.
  - reset = 1 at an edge: count = 0, every entry = 0, overflow = underflow = 0. reset has priority over any stackOP on the same edge.
  - Reset values: a = 0, b = 0, count = 0, full = 0, empty = 1, overflow = 0, underflow = 0.
- Op codes (n = count before the edge; T = top, S = second):
  - 0 nop: no change.
  - 1 push: needs n < DEPTH. New top = w, n+1.
  - 2 pop-replace: needs n ≥ 2. Removes T and S, pushes w, n-1. Used for binary ALU results.
  - 3 pop: needs n ≥ 1. n-1.
  - 4 pop2: needs n ≥ 2. n-2.
  - 5 swap: needs n ≥ 2. T and S exchanged, n unchanged.
  - 6 dup: needs n ≥ 1 and n < DEPTH. Pushes copy of T, n+1.
  - 7 over: needs n ≥ 2 and n < DEPTH. Pushes copy of S, n+1.
- Illegal ops (precondition unmet)
  - Stack contents and count are unchanged.
  - If the operand requirement fails, underflow is set. This check wins when both checks fail.
  - Otherwise, if the room requirement fails, overflow is set.
  - Once set, a flag stays set until reset; further legal ops do not clear it.
- Entry storage
  - Entries at depth ≥ count are don't-care internally but must never reach a or b.
  - Either a shift-register or a pointer-based implementation is acceptable, provided a/b/count behaviour is identical.
- Boundary cases
  - push at count == DEPTH-1: succeeds and full asserts.
  - pop at count == 1: empty asserts, a = 0.
  - pop2 at count == 2: empty asserts.
  - Repeated push/pop across the full range never corrupts deeper entries. Pointer implementations must not wrap.
- stackOP values are decoded only at the edge; no handshake and no multi-cycle ops.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on three edges -> a = 0x3333, b = 0x2222, count = 3, empty = 0.
- From count = 3 (0x3333 top), issue swap, then pop-replace with w = 0xABCD -> after swap a = 0x2222, b = 0x3333; after pop-replace a = 0xABCD, b = 0x1111, count = 2.
- dup then over on [T=0x0005, S=0x0007] -> after dup a = b = 0x0005, count+1; after over a = 0x0005, b = 0x0005, third entry 0x0005, count+1.
- Push DEPTH distinct values (i+1) -> full = 1, a = DEPTH. One more push with w = 0xFFFF -> a unchanged, count = DEPTH, overflow = 1. Then pop -> a = DEPTH-1, overflow stays 1.
- On an empty stack, pop, pop2, swap and pop-replace -> count stays 0, a = b = 0, underflow = 1, overflow = 0. Reset clears underflow.
- reset asserted on the same edge as a push of 0x1234 at count = 5 -> count = 0, a = 0, flags clear. Push on the next edge -> a = 0x1234, count = 1.
